// File: rtl/seg_scan_if.sv
// Bundles the scan strobe, frame data and registered display outputs of seg_scan_driver.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      tick_scan;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      blank_lz;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic [7:0]                seg;
    logic                      frame_done;
    logic                      overrun;

    modport master (
        output tick_scan, value, dp_mask, blank_lz,
        input  digit_sel, seg, frame_done, overrun
    );

    modport slave (
        input  tick_scan, value, dp_mask, blank_lz,
        output digit_sel, seg, frame_done, overrun
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit per tick_scan, with an anti-ghost
// blank between digits, frame-level snapshot of the data and leading-zero blanking.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int BLANK_CYC  = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       CNT_LOAD = 8'(BLANK_CYC - 1);

    typedef enum logic [1:0] {S_WAIT, S_BLANK, S_SHOW} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [7:0]              cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] snap_value, snap_value_n;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n;
    logic                    snap_blz, snap_blz_n;
    logic [NUM_DIGITS-1:0]   digit_sel, digit_sel_n;
    logic [7:0]              seg, seg_n;
    logic                    frame_done, frame_done_n;
    logic                    overrun, overrun_n;

    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lead_zero;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // lead_zero[i] is set when snapshot digits i..top are all zero; digit 0 is exempt.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run & (snap_value[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lead_zero[NUM_DIGITS-1-k] = zero_run;
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = snap_value[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_lz    = lead_zero[i] && (i != 0);
            end
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        snap_value_n = snap_value;
        snap_dp_n    = snap_dp;
        snap_blz_n   = snap_blz;
        digit_sel_n  = digit_sel;
        seg_n        = seg;
        frame_done_n = 1'b0;
        overrun_n    = 1'b0;
        case (state)
            S_WAIT, S_SHOW: begin
                if (bus.tick_scan) begin
                    if (idx == LAST_IDX) begin
                        idx_n        = '0;
                        snap_value_n = bus.value;
                        snap_dp_n    = bus.dp_mask;
                        snap_blz_n   = bus.blank_lz;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                    state_n     = S_BLANK;
                    cnt_n       = CNT_LOAD;
                    digit_sel_n = '0;
                    seg_n       = '0;
                end
            end
            S_BLANK: begin
                overrun_n = bus.tick_scan;
                if (cnt == 8'd0) begin
                    state_n      = S_SHOW;
                    digit_sel_n  = NUM_DIGITS'(1) << idx;
                    seg_n        = {cur_dp, (snap_blz && cur_lz) ? 7'h00 : decode(cur_digit)};
                    frame_done_n = (idx == LAST_IDX);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            idx        <= LAST_IDX;
            cnt        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blz   <= 1'b0;
            digit_sel  <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            snap_value <= snap_value_n;
            snap_dp    <= snap_dp_n;
            snap_blz   <= snap_blz_n;
            digit_sel  <= digit_sel_n;
            seg        <= seg_n;
            frame_done <= frame_done_n;
            overrun    <= overrun_n;
        end
    end

    assign bus.digit_sel  = digit_sel;
    assign bus.seg        = seg;
    assign bus.frame_done = frame_done;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: table of per-tick vectors plus hand sequences
// for overrun and mid-SHOW reset.
module tb_seg_scan_driver;
    localparam int N  = 8;
    localparam int BC = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(.NUM_DIGITS(N), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic        blz;
        logic [7:0]  sel;
        logic [7:0]  seg;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [31:0] v, input logic [7:0] dp, input logic blz,
                           input logic [7:0] sel, input logic [7:0] sg, input logic fd);
        vec_t e;
        e.value = v; e.dp = dp; e.blz = blz; e.sel = sel; e.seg = sg; e.fd = fd;
        vecs.push_back(e);
    endtask

    // Tick on the next edge, check the dark window, the SHOW entry and a short hold.
    task automatic run_tick(input string name, input logic [7:0] sel, input logic [7:0] sg,
                            input logic fd);
        logic bad;
        @(negedge clk);
        bus.tick_scan = 1'b1;
        @(negedge clk);
        bus.tick_scan = 1'b0;
        check({name, "_dark_at_tick"}, {bus.digit_sel, bus.seg}, 32'h0);
        bad = 1'b0;
        repeat (BC - 1) begin
            @(negedge clk);
            if (bus.digit_sel != 0 || bus.seg != 0 || bus.frame_done || bus.overrun) bad = 1'b1;
        end
        check({name, "_blank_window"}, {31'b0, bad}, 32'h0);
        @(negedge clk);
        check({name, "_digit_sel"}, {24'b0, bus.digit_sel}, {24'b0, sel});
        check({name, "_seg"}, {24'b0, bus.seg}, {24'b0, sg});
        check({name, "_frame_done"}, {31'b0, bus.frame_done}, {31'b0, fd});
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.digit_sel != sel || bus.seg != sg || bus.frame_done || bus.overrun) bad = 1'b1;
        end
        check({name, "_hold"}, {31'b0, bad}, 32'h0);
    endtask

    initial begin
        logic bad;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.tick_scan = 1'b0;
        bus.value     = 32'h12345678;
        bus.dp_mask   = 8'h00;
        bus.blank_lz  = 1'b0;

        // Frame 1: plain digits
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h01, 8'h7F, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h02, 8'h07, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h04, 8'h7D, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h08, 8'h6D, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h10, 8'h66, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h20, 8'h4F, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h40, 8'h5B, 1'b0);
        add_vec(32'h12345678, 8'h00, 1'b0, 8'h80, 8'h06, 1'b1);
        // Frame 2: leading-zero blanking + dp; inputs change mid-frame (must not tear)
        add_vec(32'h00000705, 8'h04, 1'b1, 8'h01, 8'h6D, 1'b0);
        add_vec(32'h00000705, 8'h04, 1'b1, 8'h02, 8'h3F, 1'b0);
        add_vec(32'h00000705, 8'h04, 1'b1, 8'h04, 8'h87, 1'b0);
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h08, 8'h00, 1'b0);
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h10, 8'h00, 1'b0);
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h20, 8'h00, 1'b0);
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h40, 8'h00, 1'b0);
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b1);
        // Frame 3: nines with all dps, again with mid-frame input change
        add_vec(32'h99999999, 8'hFF, 1'b0, 8'h01, 8'hEF, 1'b0);
        for (int i = 1; i < 8; i++)
            add_vec(32'h00000000, 8'h00, 1'b1, 8'(1 << i), 8'hEF, (i == 7));
        // Frame 4: all zero with blanking, digit 0 stays lit
        add_vec(32'h00000000, 8'h00, 1'b1, 8'h01, 8'h3F, 1'b0);
        for (int i = 1; i < 8; i++)
            add_vec(32'hFEDCBA98, 8'h00, 1'b0, 8'(1 << i), 8'h00, (i == 7));
        // Frame 5: hex codes decode to dash
        add_vec(32'hFEDCBA98, 8'h00, 1'b0, 8'h01, 8'h7F, 1'b0);
        add_vec(32'hFEDCBA98, 8'h00, 1'b0, 8'h02, 8'h6F, 1'b0);
        add_vec(32'hFEDCBA98, 8'h00, 1'b0, 8'h04, 8'h40, 1'b0);
        add_vec(32'hFEDCBA98, 8'h00, 1'b0, 8'h08, 8'h40, 1'b0);

        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.digit_sel, bus.seg, 14'b0, bus.frame_done, bus.overrun}, 32'h0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.digit_sel != 0 || bus.seg != 0 || bus.frame_done || bus.overrun) bad = 1'b1;
        end
        check("wait_dark", {31'b0, bad}, 32'h0);

        foreach (vecs[i]) begin
            bus.value    = vecs[i].value;
            bus.dp_mask  = vecs[i].dp;
            bus.blank_lz = vecs[i].blz;
            run_tick($sformatf("vec%0d", i), vecs[i].sel, vecs[i].seg, vecs[i].fd);
        end

        // Overrun: second tick 5 cycles after the first is ignored
        @(negedge clk);
        bus.tick_scan = 1'b1;
        @(negedge clk);
        bus.tick_scan = 1'b0;
        repeat (4) @(negedge clk);
        bus.tick_scan = 1'b1;
        @(negedge clk);
        bus.tick_scan = 1'b0;
        check("ovr_pulse", {31'b0, bus.overrun}, 32'h1);
        check("ovr_dark", {24'b0, bus.digit_sel}, 32'h0);
        @(negedge clk);
        check("ovr_one_cycle", {31'b0, bus.overrun}, 32'h0);
        repeat (9) @(negedge clk);
        check("ovr_still_blank", {bus.digit_sel, bus.seg}, 32'h0);
        @(negedge clk);
        check("ovr_show_sel", {24'b0, bus.digit_sel}, 32'h10);
        check("ovr_show_seg", {24'b0, bus.seg}, 32'h40);

        // Asynchronous reset in SHOW, then dark until the next tick restarts at digit 0
        #2 rst_n = 1'b0;
        #1 check("async_reset_dark", {bus.digit_sel, bus.seg}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.value    = 32'h00000003;
        bus.dp_mask  = 8'h00;
        bus.blank_lz = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.digit_sel != 0 || bus.seg != 0 || bus.frame_done || bus.overrun) bad = 1'b1;
        end
        check("post_reset_dark", {31'b0, bad}, 32'h0);
        run_tick("post_reset", 8'h01, 8'h4F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, anti-ghost blank length in clk cycles (1..255).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_scan  input  1  one-cycle scan strobe, nominally every 1 ms.
REQ-006 value  input  4*NUM_DIGITS  BCD digits; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-007 dp_mask  input  NUM_DIGITS  decimal point enable per digit.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 digit_sel  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-010 seg  output  8  segments: seg[6:0] = g..a, seg[7] = dp, active-high.
REQ-011 frame_done  output  1  one-cycle pulse when the last digit of a frame is shown.
REQ-012 overrun  output  1  one-cycle pulse when tick_scan arrives during BLANK.

Function
REQ-013 The block SHALL have states WAIT (post-reset, dark), BLANK and SHOW, plus a digit index idx and a blank counter.
REQ-014 A tick_scan sampled in WAIT or SHOW SHALL advance idx (NUM_DIGITS-1 wraps to 0), enter BLANK, load the counter with BLANK_CYC-1, and drive digit_sel=0 and seg=0 from that edge.
REQ-015 In BLANK the counter SHALL decrement each cycle; on the cycle it reads 0 the block SHALL enter SHOW, so SHOW outputs are valid exactly BLANK_CYC cycles after the tick edge.
REQ-016 In SHOW the block SHALL drive digit_sel = one-hot(idx) and seg = decode(snapshot digit idx), held until the next tick.
REQ-017 When idx advances to 0, the block SHALL capture value, dp_mask and blank_lz into a snapshot on the same edge; no other edge SHALL update the snapshot (no tearing within a frame).
REQ-018 Decode SHALL map 0..9 to 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F on seg[6:0]; codes A..F SHALL map to 0x40 (dash).
REQ-019 seg[7] SHALL equal snapshot dp_mask[idx] in SHOW and 0 elsewhere.
REQ-020 With snapshot blank_lz=1, digit i>0 SHALL show seg[6:0]=0 if snapshot digits i..NUM_DIGITS-1 are all 0; digit 0 SHALL never be blanked; digit_sel and dp SHALL be unaffected.
REQ-021 frame_done SHALL pulse for one cycle on the edge entering SHOW with idx=NUM_DIGITS-1.
REQ-022 A tick_scan sampled in BLANK SHALL be ignored (idx, counter and snapshot unchanged) and SHALL pulse overrun for one cycle.
REQ-023 digit_sel SHALL never have more than one bit set, and SHALL be all-zero in WAIT and BLANK.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n=0, the block SHALL force state=WAIT, idx=NUM_DIGITS-1, counter=0, snapshot=0, digit_sel=0, seg=0, frame_done=0 and overrun=0, regardless of clk.
REQ-026 Reset assertion mid-BLANK or mid-SHOW SHALL blank outputs immediately; after release, outputs SHALL stay dark until the first tick_scan, which SHALL select digit 0 and take a fresh snapshot.

Verification
REQ-027 After reset, value=0x12345678, dp_mask=0, blank_lz=0, first tick at edge k -> digit_sel=0 and seg=0 for edges k..k+15; digit_sel=0x01, seg=0x7F (digit '8') at edge k+16.
REQ-028 Eight ticks spaced 50000 cycles apart -> digit_sel walks 0x01..0x80 with seg 0x7F,0x07,0x7D,0x6D,0x66,0x4F,0x5B,0x06; frame_done pulses once, at the 0x80 SHOW entry; the ninth tick returns to 0x01.
REQ-029 value=0x00000705, blank_lz=1, dp_mask=0x04 -> digits 7..3 seg=0x00; digit 2 seg=0x87; digit 1 seg=0x3F; digit 0 seg=0x6D.
REQ-030 value changed to 0x99999999 while idx=3 -> digits 4..7 of the current frame still show the old snapshot; new digits appear from the next digit 0 onward.
REQ-031 Second tick 5 cycles after the first (BLANK_CYC=16) -> overrun pulses one cycle, and SHOW still starts at first tick +16 on the same digit.
REQ-032 Digit value 0xA, then rst_n pulsed low for 1 cycle during SHOW -> seg shows 0x40 before reset; digit_sel=0 and seg=0 asynchronously during reset; dark until the next tick.
